// File: rtl/fixed_point_sub_sat_if.sv
// Stream bundle for the fixed-point subtractor.
// Input pair and output result, each with valid/ready.
interface fixed_point_sub_sat_if #(
  parameter int AW = 17,
  parameter int BW = 17,
  parameter int OW = 18
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] diff;
  logic          overflow;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output overflow
  );
endinterface

// File: rtl/fixed_point_sub_sat.sv
// Pipelined signed fixed-point subtractor, diff = a - b.
// Align, subtract, then rescale with round/saturate.
module fixed_point_sub_sat #(
  parameter int A_INT    = 3,
  parameter int A_FRAC   = 14,
  parameter int B_INT    = 3,
  parameter int B_FRAC   = 14,
  parameter int OUT_INT  = 4,
  parameter int OUT_FRAC = 14,
  parameter int ROUND    = 0,
  parameter int SATURATE = 1
) (
  input logic              clk,
  input logic              rst,
  fixed_point_sub_sat_if.slave io
);

  localparam int GI  = (A_INT > B_INT) ? A_INT : B_INT;
  localparam int GF  = (A_FRAC > B_FRAC) ? A_FRAC : B_FRAC;
  localparam int AL  = GI + GF;
  localparam int W   = AL + 1;
  localparam int OW  = OUT_INT + OUT_FRAC;
  localparam int S   = GF - OUT_FRAC;
  localparam int SR  = (S > 0) ? S : 0;
  localparam int SL  = (S < 0) ? -S : 0;
  localparam int RW0 = W + 1 + SL;
  localparam int RW  = (RW0 > OW + 1) ? RW0 : OW + 1;

  // Half-LSB bias only exists when fraction bits are dropped.
  localparam logic signed [RW-1:0] RND =
    (ROUND != 0 && SR > 0) ?
      (RW'(1) <<< ((SR > 0) ? SR - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] ONE_OW = RW'(1) <<< (OW - 1);
  localparam logic signed [RW-1:0] MAXV   = ONE_OW - RW'(1);
  localparam logic signed [RW-1:0] MINV   = -ONE_OW;

  logic v1;
  logic v2;
  logic v3;
  logic rdy1;
  logic rdy2;
  logic rdy3;

  logic signed [AL-1:0] a_al;
  logic signed [AL-1:0] b_al;
  logic signed [AL-1:0] a1;
  logic signed [AL-1:0] b1;
  logic signed [W-1:0]  d_c;
  logic signed [W-1:0]  d2;
  logic signed [RW-1:0] r_c;
  logic [OW-1:0]        diff_c;
  logic                 ovf_c;
  logic [OW-1:0]        diff_q;
  logic                 ovf_q;

  assign rdy3 = !v3 || io.out_ready;
  assign rdy2 = !v2 || rdy3;
  assign rdy1 = !v1 || rdy2;

  assign io.in_ready  = rdy1 && !rst;
  assign io.out_valid = v3;
  assign io.diff      = diff_q;
  assign io.overflow  = ovf_q;

  // Sign-extend the integer part, zero-pad the fraction.
  assign a_al = AL'($signed(io.a)) <<< (GF - A_FRAC);
  assign b_al = AL'($signed(io.b)) <<< (GF - B_FRAC);

  // One extra bit makes the difference exact.
  assign d_c = W'(a1) - W'(b1);

  // Rescale to the output grid in a width that never overflows.
  always_comb begin
    r_c = ((RW'(d2) + RND) >>> SR) <<< SL;
  end

  // Range check, then clamp or wrap.
  always_comb begin
    ovf_c  = (r_c > MAXV) || (r_c < MINV);
    diff_c = r_c[OW-1:0];
    if (SATURATE != 0) begin
      if (r_c > MAXV) begin
        diff_c = MAXV[OW-1:0];
      end else if (r_c < MINV) begin
        diff_c = MINV[OW-1:0];
      end
    end
  end

  // S1: capture the aligned operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
    end else if (rdy1) begin
      v1 <= io.in_valid;
      a1 <= a_al;
      b1 <= b_al;
    end
  end

  // S2: capture the full-precision difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      d2 <= '0;
    end else if (rdy2) begin
      v2 <= v1;
      d2 <= d_c;
    end
  end

  // S3: capture the rescaled result and its overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3     <= 1'b0;
      diff_q <= '0;
      ovf_q  <= 1'b0;
    end else if (rdy3) begin
      v3     <= v2;
      diff_q <= diff_c;
      ovf_q  <= ovf_c;
    end
  end

endmodule

// File: doc/fixed_point_sub_sat.md
Name: fixed_point_sub_sat

Overview:
- Pipelined signed fixed-point subtractor: diff = A - B.
- Aligns two independently formatted operands, subtracts at full precision, then rescales to the output format with optional rounding and saturation.
- Companion to the fixed-point adder in the arithmetic datapath. Uses valid/ready handshakes on both sides so it can sit in back-pressured streams.

Parameters:
- A_INT, 3: integer bits of A, sign included.
- A_FRAC, 14: fractional bits of A.
- B_INT, 3: integer bits of B, sign included.
- B_FRAC, 14: fractional bits of B.
- OUT_INT, 4: integer bits of diff, sign included.
- OUT_FRAC, 14: fractional bits of diff.
- ROUND, 0: 0 = truncate toward -inf; 1 = round half up when discarding fraction bits.
- SATURATE, 1: 1 = clamp out-of-range results; 0 = wrap (keep low bits).
- Derived: GI = max(A_INT, B_INT), GF = max(A_FRAC, B_FRAC), W = GI+GF+1, OW = OUT_INT+OUT_FRAC.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- in_valid, in, 1: a/b valid.
- in_ready, out, 1: block accepts a/b this cycle.
- a, in, A_INT+A_FRAC: signed minuend.
- b, in, B_INT+B_FRAC: signed subtrahend.
- out_valid, out, 1: diff/overflow valid.
- out_ready, in, 1: consumer accepts the result.
- diff, out, OW: signed result.
- overflow, out, 1: the true rounded result did not fit in OW bits.

Behaviour:
- Reset is synchronous on rst at posedge clk. Reset values: all stage valids = 0, out_valid = 0, diff = 0, overflow = 0. in_ready = 0 while rst is high.
- Transfer rules: input transfer occurs on in_valid && in_ready; output transfer on out_valid && out_ready.
- Pipeline has 3 register stages, each with its own valid bit:
  - S1 (align): integer parts sign-extended to GI bits; fraction parts zero-padded on the LSB side to GF bits. Stored as (GI+GF)-bit signed.
  - S2 (subtract): W-bit signed difference. Exact; cannot overflow internally.
  - S3 (rescale/check): result presented on diff/overflow; out_valid = S3 valid.
- Rescale, with shift s = GF - OUT_FRAC:
  - s > 0, ROUND=0: arithmetic shift right by s.
  - s > 0, ROUND=1: add 2^(s-1) in a W+1-bit signed temp, then arithmetic shift right by s.
  - s = 0: no change.
  - s < 0: shift left by -s, zero fill.
  - Rescaled value R is held in a width wide enough to be exact.
- Range check and output:
  - overflow = 1 when R > 2^(OW-1)-1 or R < -2^(OW-1).
  - SATURATE=1: diff clamps to 2^(OW-1)-1 or -2^(OW-1).
  - SATURATE=0: diff = R[OW-1:0].
  - overflow is reported in both modes and is qualified by out_valid.
- Latency and throughput: 3 cycles from input transfer to out_valid with out_ready held high. Full throughput is 1 result per cycle.
- Backpressure (elastic pipeline):
  - ready3 = !v3 || out_ready; ready2 = !v2 || ready3; ready1 = !v1 || ready2; in_ready = ready1 (combinational, no bubble).
  - A stage loads only when its downstream ready is high. Otherwise it holds data and valid unchanged.
  - Capacity is 3 in-flight results. With out_ready = 0 and all stages full, in_ready = 0.
- Ordering: results leave in strict input order. No drop, no duplication.
- Output stability: while out_valid && !out_ready, diff and overflow are held stable.
- Simultaneous events: an output transfer and an input transfer in the same cycle with a full pipeline are legal. Every stage advances; no loss.
- Reset mid-operation: all in-flight results are discarded. out_valid = 0 the cycle after rst is sampled high. Nothing emitted until new inputs arrive.
- Elaboration: parameter widths must be ≥1. OUT_FRAC may exceed GF.

Test Plan:
- Defaults (Q3.14 in, Q4.14 out): a=24576 (1.5), b=4096 (0.25) -> 3 cycles later out_valid=1, diff=20480 (1.25), overflow=0. Also a=65535, b=-65536 -> diff=131071, overflow=0.
- OUT_INT=3, SATURATE=1: a=65535, b=-65536 -> diff=65535, overflow=1. a=-65536, b=1 -> diff=-65536, overflow=1. With SATURATE=0, same first pair -> diff=-1 (wrapped), overflow=1.
- OUT_FRAC=12 (s=2): a=3, b=0 -> ROUND=1 diff=1, ROUND=0 diff=0. a=-2, b=0 -> ROUND=1 diff=0, ROUND=0 diff=-1.
- Mixed formats, A Q2.6, B Q4.2, out Q5.6: a=64 (1.0), b=-10 (-2.5) -> diff=224 (3.5), overflow=0.
- Backpressure: hold out_ready=0 and offer 5 back-to-back pairs -> exactly 3 accepted, then in_ready=0. diff stays constant. Then raise out_ready -> remaining results emerge in order, one per cycle, and in_ready rises the same cycle.
- Reset mid-stream: assert rst for 1 cycle with 3 results in flight -> out_valid=0 next cycle, diff=0, overflow=0. A following input yields its result exactly 3 cycles after acceptance.
